// File: rtl/harness_pkg.sv
// Shared constants for the simulation-harness controller: state codes,
// tohost success value and the default snoop addresses.
package harness_pkg;

  localparam logic [2:0] ST_RESET_HOLD = 3'd0;
  localparam logic [2:0] ST_RUN        = 3'd1;
  localparam logic [2:0] ST_DONE       = 3'd2;
  localparam logic [2:0] ST_TIMEOUT    = 3'd3;

  localparam int unsigned TOHOST_PASS = 1;

  localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_1000;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h0000_1004;

  function automatic logic is_terminal(input logic [2:0] s);
    return (s == ST_DONE) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                q <= '0;
    else if (clr)              q <= '0;
    else if (en && (q != '1))  q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/sim_harness_ctrl.sv
// Harness controller beside the core: sequences core reset, counts RUN cycles
// and retirements, snoops tohost/console writes and flags done/pass/timeout.
module sim_harness_ctrl
  import harness_pkg::*;
#(
  parameter int                XLEN         = 32,
  parameter int                ADDR_W       = 32,
  parameter int                CNT_W        = 32,
  parameter int                RESET_CYCLES = 4,
  parameter int                MAX_CYCLES   = 1500,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(DEF_TOHOST_ADDR),
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(DEF_CONSOLE_ADDR),
  parameter bit                HOLD_ON_DONE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              retire_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [XLEN-2:0]   exit_code,
  output logic              char_valid,
  output logic [7:0]        char_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count,
  output logic [2:0]        state
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;
  logic [2:0]        state_d;
  logic              in_hold, run, hold_last;
  logic              tohost_hit, console_hit, budget_end, leave_run;

  assign in_hold     = (state == ST_RESET_HOLD);
  assign run         = (state == ST_RUN);
  assign hold_last   = in_hold && (hold_q == HOLD_LAST);
  assign tohost_hit  = run && mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  assign console_hit = run && mem_we && (mem_addr == CONSOLE_ADDR);
  assign budget_end  = run && (cycle_count == CNT_LAST);
  // the exit cycle is not counted, so the counters hold their last RUN values
  assign leave_run   = tohost_hit || budget_end;

  sat_counter #(.WIDTH(HOLD_W)) u_hold (
    .clock (clock),
    .reset (reset),
    .en    (in_hold),
    .clr   (!in_hold),
    .q     (hold_q)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cycle (
    .clock (clock),
    .reset (reset),
    .en    (run && !leave_run),
    .clr   (1'b0),
    .q     (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_instret (
    .clock (clock),
    .reset (reset),
    .en    (run && !leave_run && retire_valid),
    .clr   (1'b0),
    .q     (instret_count)
  );

  always_comb begin
    state_d = ST_RESET_HOLD;
    case (state)
      ST_RESET_HOLD: state_d = hold_last ? ST_RUN : ST_RESET_HOLD;
      ST_RUN: begin
        if (tohost_hit)      state_d = ST_DONE;
        else if (budget_end) state_d = ST_TIMEOUT;
        else                 state_d = ST_RUN;
      end
      ST_DONE:               state_d = ST_DONE;
      ST_TIMEOUT:            state_d = ST_TIMEOUT;
      default:               state_d = ST_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_RESET_HOLD;
      core_reset <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      exit_code  <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
    end else begin
      state      <= state_d;
      // terminal states see core_reset drop one cycle after entry
      core_reset <= hold_last || run || (is_terminal(state) && !HOLD_ON_DONE);
      char_valid <= console_hit && !leave_run;
      if (console_hit && !leave_run)
        char_data <= mem_wdata[7:0];
      if (tohost_hit) begin
        done      <= 1'b1;
        pass      <= (mem_wdata == XLEN'(TOHOST_PASS));
        exit_code <= mem_wdata[XLEN-1:1];
      end else if (budget_end) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Directed-plus-random bench for sim_harness_ctrl against a cycle-level
// reference model of the harness rules.
module tb_sim_harness_ctrl;

  localparam int          RC      = 4;
  localparam int          MAXC    = 24;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam logic [31:0] CONSOLE = 32'h0000_1004;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        retire_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        core_reset, done, pass, timeout, char_valid;
  logic [30:0] exit_code;
  logic [7:0]  char_data;
  logic [31:0] cycle_count, instret_count;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  // reference model
  int          m_state, m_cyc, m_ret;
  bit          m_cr, m_done, m_pass, m_to, m_cv;
  logic [7:0]  m_cd;
  logic [30:0] m_exit;

  sim_harness_ctrl #(
    .XLEN(32), .ADDR_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
    .TOHOST_ADDR(TOHOST), .CONSOLE_ADDR(CONSOLE), .HOLD_ON_DONE(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .retire_valid(retire_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset(core_reset),
    .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code),
    .char_valid(char_valid), .char_data(char_data), .cycle_count(cycle_count),
    .instret_count(instret_count), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",      64'(state),         64'(m_state));
    chk("core_reset", 64'(core_reset),    64'(m_cr));
    chk("done",       64'(done),          64'(m_done));
    chk("pass",       64'(pass),          64'(m_pass));
    chk("timeout",    64'(timeout),       64'(m_to));
    chk("exit_code",  64'(exit_code),     64'(m_exit));
    chk("char_valid", 64'(char_valid),    64'(m_cv));
    chk("char_data",  64'(char_data),     64'(m_cd));
    chk("cycle",      64'(cycle_count),   64'(m_cyc));
    chk("instret",    64'(instret_count), 64'(m_ret));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // one clock with the given inputs; model advances from the spec rules
  task automatic cyc(input bit rv, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit running, th, last;
    retire_valid = rv; mem_we = we; mem_addr = a; mem_wdata = d;
    running = (m_state == 1);
    th      = running && we && (a == TOHOST) && d[0];
    last    = running && (m_cyc == MAXC - 1);
    if (m_done) m_cr = 1'b0;
    m_cv = 1'b0;
    if (th) begin
      m_state = 2; m_done = 1'b1; m_pass = (d == 32'd1); m_exit = d[31:1];
    end else if (last) begin
      m_state = 3; m_done = 1'b1; m_to = 1'b1; m_pass = 1'b0;
    end else if (running) begin
      m_cyc++;
      if (rv) m_ret++;
      if (we && a == CONSOLE) begin m_cv = 1'b1; m_cd = d[7:0]; end
    end
    tick();
    check_all();
  endtask

  // random RUN traffic that never contains a qualifying tohost write
  task automatic random_run(input int n);
    logic [31:0] a, d;
    bit rv, we;
    for (int i = 0; i < n; i++) begin
      rv = $urandom_range(0, 1) == 1;
      if (m_cyc == MAXC - 1) rv = 1'b0;
      d  = $urandom;
      we = 1'b1;
      case ($urandom_range(0, 4))
        0: a = CONSOLE;
        1: begin a = TOHOST; d[0] = 1'b0; end
        2: a = 32'h8000_0000 | $urandom;
        3: begin a = TOHOST ^ (32'd1 << $urandom_range(0, 31)); d[0] = 1'b1; end
        default: begin we = 1'b0; a = TOHOST; d[0] = 1'b1; end
      endcase
      cyc(rv, we, a, d);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    m_state = 0; m_cr = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_to = 1'b0;
    m_cv = 1'b0; m_cd = '0; m_exit = '0; m_cyc = 0; m_ret = 0;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < RC; i++) begin
      chk("hold_core_reset", 64'(core_reset), 64'd0);
      chk("hold_state", 64'(state), 64'd0);
      retire_valid = 1'b1; mem_we = 1'b1;
      mem_addr = (i % 2 == 1) ? TOHOST : CONSOLE;
      mem_wdata = 32'h0000_0001;
      tick();
    end
    retire_valid = 1'b0; mem_we = 1'b0;
    m_state = 1; m_cr = 1'b1;
    check_all();
  endtask

  initial begin
    logic [31:0] d;

    // A: 20 RUN cycles with console traffic, then passing tohost
    apply_reset();
    random_run(8);
    cyc(1'b0, 1'b1, CONSOLE, 32'h0000_0048);
    cyc(1'b0, 1'b1, CONSOLE, 32'h0000_0069);
    cyc(1'b1, 1'b0, CONSOLE, 32'h0000_0055);
    cyc(1'b1, 1'b1, TOHOST,  32'h0000_0002);
    random_run(8);
    chk("A_cycle_before", 64'(cycle_count), 64'd20);
    cyc(1'b0, 1'b1, TOHOST, 32'h0000_0001);
    chk("A_pass", 64'(pass), 64'd1);
    chk("A_cycle_final", 64'(cycle_count), 64'd20);
    cyc(1'b1, 1'b1, TOHOST, 32'h0000_0007);
    chk("A_core_reset_held", 64'(core_reset), 64'd0);
    cyc(1'b1, 1'b1, CONSOLE, 32'h0000_0041);

    // B: failing tohost, later pass write ignored
    apply_reset();
    random_run(5);
    cyc(1'b0, 1'b1, TOHOST, 32'h0000_0007);
    chk("B_exit", 64'(exit_code), 64'd3);
    cyc(1'b0, 1'b1, TOHOST, 32'h0000_0001);
    chk("B_pass_sticky", 64'(pass), 64'd0);

    // C: budget exhausted
    apply_reset();
    random_run(MAXC - 1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk("C_timeout", 64'(timeout), 64'd1);
    chk("C_cycle_frozen", 64'(cycle_count), 64'(MAXC - 1));
    cyc(1'b1, 1'b1, TOHOST, 32'h0000_0001);
    cyc(1'b1, 1'b1, TOHOST, 32'h0000_0001);

    // D: tohost on the last budget cycle wins
    apply_reset();
    random_run(MAXC - 1);
    cyc(1'b0, 1'b1, TOHOST, 32'h0000_0001);
    chk("D_pass", 64'(pass), 64'd1);
    chk("D_no_timeout", 64'(timeout), 64'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);

    // E: async reset mid-RUN, hold sequence and counters restart
    apply_reset();
    random_run(7);
    apply_reset();
    random_run(3);
    chk("E_cycle_restart", 64'(cycle_count), 64'd3);

    // F: random odd tohost payloads
    for (int k = 0; k < 4; k++) begin
      apply_reset();
      random_run($urandom_range(0, 10));
      d = $urandom | 32'd1;
      if (k == 0) d = 32'h0000_0001;
      cyc(1'b0, 1'b1, TOHOST, d);
      cyc(1'b1, 1'b1, CONSOLE, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
